universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
Parameterisable universal shift register with four modes: hold, shift right, shift left and parallel load. The mode is chosen by a 2-bit select.
- Parallel data is visible at all times on p_dout.
- Serial outputs expose the bit that the next shift in each direction would push out.
- Used as a generic datapath/serialiser building block. Blocks can be chained through the serial inputs and outputs.

Parameters:
WIDTH, 4, register width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  reset, asynchronous, active-low
select  input  2  mode select: 0 hold, 1 shift right, 2 shift left, 3 parallel load
p_din  input  WIDTH  parallel load data
s_left_din  input  1  serial input entering at bit 0 during a left shift
s_right_din  input  1  serial input entering at bit WIDTH-1 during a right shift
p_dout  output  WIDTH  register contents
s_left_dout  output  1  left-serial output, equal to p_dout[WIDTH-1]
s_right_dout  output  1  right-serial output, equal to p_dout[0]

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is 0:
  - p_dout is 4'b0000 (all zeros for any WIDTH), so s_left_dout and s_right_dout are 0.
  - Assertion takes effect immediately, without waiting for a clock edge.
- Reset release: the first update happens on the first rising clk edge after rst_n goes to 1.
- On each rising clk edge with rst_n=1:
  - select=0 (hold): p_dout is unchanged.
  - select=1 (shift right): p_dout <= {s_right_din, p_dout[WIDTH-1:1]}. The old bit 0 is discarded.
  - select=2 (shift left): p_dout <= {p_dout[WIDTH-2:0], s_left_din}. The old MSB is discarded.
  - select=3 (parallel load): p_dout <= p_din.
- Latency: p_dout reflects the operation one edge after inputs are sampled. There are no multi-cycle operations and no handshake.
- Serial outputs are purely combinational from the register: s_left_dout = p_dout[WIDTH-1] and s_right_dout = p_dout[0]. There is no extra flop.
- X or Z on select is undefined behaviour. Synthesis treats any non-1/2/3 code as hold.
- Serial inputs are sampled only in their own shift mode. In all other modes they are ignored.
- Asserting reset mid-shift or mid-load clears the register immediately. The operation in progress is lost, and nothing is resumed after release.
- All inputs must be stable around the rising edge. There is no internal synchronisation.

Decomposition:
- Shared package usr_pkg holds:
  - localparams for the select encoding: SEL_HOLD=2'd0, SEL_SHR=2'd1, SEL_SHL=2'd2, SEL_LOAD=2'd3.
  - typedef usr_sel_t for the 2-bit select.
- Optional sub-module usr_bit_cell: a one-bit 4:1 mux plus flop, with inputs self, right neighbour, left neighbour and parallel bit. It is instantiated WIDTH times with a generate loop, and boundary cells take the serial inputs.
- A flat single always_ff case statement is equally acceptable.

Test Plan:
- Reset: rst_n=0 with clocks running -> p_dout=0000, s_left_dout=0, s_right_dout=0. Assert rst_n=0 asynchronously between edges after loading 1111 -> p_dout=0000 immediately, before the next edge.
- Parallel load: rst_n=1, select=3, p_din=1101 -> after 1 edge p_dout=1101, s_left_dout=1, s_right_dout=1.
- Shift right: from 1101, select=1, s_right_din=0 -> successive edges give 0110, 0011, 0001, 0000. With s_right_din=1 from 0000 -> 1000, 1100.
- Shift left: load 1101, then select=2, s_left_din=1 -> successive edges give 1011, 0111, 1111, 1111. s_left_dout tracks bit 3: 1, 0, 1, 1.
- Hold: load 1010, select=0 for 5 edges while p_din, s_left_din and s_right_din toggle -> p_dout stays 1010.
- Mode switching: load 0001, then one edge each of shift-left (s_left_din=0), shift-right (s_right_din=1) and load p_din=0110 -> 0010, 1001, 0110. Also repeat the width checks with WIDTH=8.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared select encoding for the universal shift register
package usr_pkg;

    typedef logic [1:0] usr_sel_t;

    localparam usr_sel_t SEL_HOLD = 2'd0;
    localparam usr_sel_t SEL_SHR  = 2'd1;
    localparam usr_sel_t SEL_SHL  = 2'd2;
    localparam usr_sel_t SEL_LOAD = 2'd3;

endpackage

// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - mode/data bundle between a shift register and its user
interface universal_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
);

    usr_sel_t         select;
    logic [WIDTH-1:0] p_din;
    logic             s_left_din;
    logic             s_right_din;
    logic [WIDTH-1:0] p_dout;
    logic             s_left_dout;
    logic             s_right_dout;

    modport master (
        output select, p_din, s_left_din, s_right_din,
        input  p_dout, s_left_dout, s_right_dout
    );

    modport slave (
        input  select, p_din, s_left_din, s_right_din,
        output p_dout, s_left_dout, s_right_dout
    );

endinterface

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one register bit: 4:1 mode mux feeding a flop
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  usr_sel_t select,
    input  logic     right_nbr,
    input  logic     left_nbr,
    input  logic     p_bit,
    output logic     q
);

    // right_nbr feeds a right shift, left_nbr feeds a left shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (select)
                SEL_HOLD: q <= q;
                SEL_SHR:  q <= right_nbr;
                SEL_SHL:  q <= left_nbr;
                SEL_LOAD: q <= p_bit;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - hold / shift-right / shift-left / parallel-load register
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    universal_shift_reg_if.slave  bus
);

    logic [WIDTH-1:0] q;

    // Edge cells take the serial inputs in place of a missing neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic right_nbr;
        logic left_nbr;

        if (i == WIDTH - 1) begin : g_msb
            assign right_nbr = bus.s_right_din;
        end else begin : g_mid_r
            assign right_nbr = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign left_nbr = bus.s_left_din;
        end else begin : g_mid_l
            assign left_nbr = q[i-1];
        end

        usr_bit_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .select    (bus.select),
            .right_nbr (right_nbr),
            .left_nbr  (left_nbr),
            .p_bit     (bus.p_din[i]),
            .q         (q[i])
        );
    end

    assign bus.p_dout       = q;
    assign bus.s_left_dout  = q[WIDTH-1];
    assign bus.s_right_dout = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;
    import usr_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    universal_shift_reg_if #(.WIDTH(4)) bus4 ();
    universal_shift_reg_if #(.WIDTH(8)) bus8 ();

    universal_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    universal_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive4(input usr_sel_t sel, input logic [3:0] din, input logic sl, input logic sr);
        bus4.select      = sel;
        bus4.p_din       = din;
        bus4.s_left_din  = sl;
        bus4.s_right_din = sr;
    endtask

    task automatic drive8(input usr_sel_t sel, input logic [7:0] din, input logic sl, input logic sr);
        bus8.select      = sel;
        bus8.p_din       = din;
        bus8.s_left_din  = sl;
        bus8.s_right_din = sr;
    endtask

    task automatic check4(input string tag, input logic [3:0] p, input logic sl, input logic sr);
        check({tag, "_p"},  {4'h0, bus4.p_dout}, {4'h0, p});
        check({tag, "_sl"}, {7'h0, bus4.s_left_dout}, {7'h0, sl});
        check({tag, "_sr"}, {7'h0, bus4.s_right_dout}, {7'h0, sr});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive4(SEL_HOLD, 4'h0, 1'b0, 1'b0);
        drive8(SEL_HOLD, 8'h00, 1'b0, 1'b0);

        // reset held with clocks running
        step();
        step();
        check4("reset", 4'b0000, 1'b0, 1'b0);
        check("reset8", bus8.p_dout, 8'h00);

        rst_n = 1'b1;

        // parallel load
        drive4(SEL_LOAD, 4'b1101, 1'b0, 1'b0);
        step();
        check4("load1101", 4'b1101, 1'b1, 1'b1);

        // shift right with zeros, then ones
        drive4(SEL_SHR, 4'b0000, 1'b0, 1'b0);
        step(); check4("shr0_a", 4'b0110, 1'b0, 1'b0);
        step(); check4("shr0_b", 4'b0011, 1'b0, 1'b1);
        step(); check4("shr0_c", 4'b0001, 1'b0, 1'b1);
        step(); check4("shr0_d", 4'b0000, 1'b0, 1'b0);
        drive4(SEL_SHR, 4'b0000, 1'b0, 1'b1);
        step(); check4("shr1_a", 4'b1000, 1'b1, 1'b0);
        step(); check4("shr1_b", 4'b1100, 1'b1, 1'b0);

        // shift left with ones
        drive4(SEL_LOAD, 4'b1101, 1'b0, 1'b0);
        step(); check4("load1101b", 4'b1101, 1'b1, 1'b1);
        drive4(SEL_SHL, 4'b0000, 1'b1, 1'b0);
        step(); check4("shl1_a", 4'b1011, 1'b1, 1'b1);
        step(); check4("shl1_b", 4'b0111, 1'b0, 1'b1);
        step(); check4("shl1_c", 4'b1111, 1'b1, 1'b1);
        step(); check4("shl1_d", 4'b1111, 1'b1, 1'b1);

        // hold ignores every data input
        drive4(SEL_LOAD, 4'b1010, 1'b0, 1'b0);
        step(); check4("load1010", 4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive4(SEL_HOLD, (i % 2 == 0) ? 4'b0101 : 4'b1111, i[0], ~i[0]);
            step();
            check4($sformatf("hold_%0d", i), 4'b1010, 1'b1, 1'b0);
        end

        // mode switching
        drive4(SEL_LOAD, 4'b0001, 1'b1, 1'b1);
        step(); check4("load0001", 4'b0001, 1'b0, 1'b1);
        drive4(SEL_SHL, 4'b1111, 1'b0, 1'b0);
        step(); check4("sw_shl", 4'b0010, 1'b0, 1'b0);
        drive4(SEL_SHR, 4'b1111, 1'b0, 1'b1);
        step(); check4("sw_shr", 4'b1001, 1'b1, 1'b1);
        drive4(SEL_LOAD, 4'b0110, 1'b1, 1'b1);
        step(); check4("sw_load", 4'b0110, 1'b0, 1'b0);

        // asynchronous reset between edges, operation not resumed after release
        drive4(SEL_LOAD, 4'b1111, 1'b0, 1'b0);
        step(); check4("load1111", 4'b1111, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check4("async_rst", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive4(SEL_HOLD, 4'b1111, 1'b1, 1'b1);
        step(); check4("post_rst", 4'b0000, 1'b0, 1'b0);

        // WIDTH=8 instance
        drive8(SEL_LOAD, 8'b1011_0011, 1'b0, 1'b0);
        step(); check("w8_load", bus8.p_dout, 8'b1011_0011);
        drive8(SEL_SHR, 8'h00, 1'b0, 1'b1);
        step(); check("w8_shr", bus8.p_dout, 8'b1101_1001);
        check("w8_shr_sr", {7'h0, bus8.s_right_dout}, 8'h01);
        drive8(SEL_SHL, 8'h00, 1'b0, 1'b1);
        step(); check("w8_shl", bus8.p_dout, 8'b1011_0010);
        check("w8_shl_sl", {7'h0, bus8.s_left_dout}, 8'h01);
        check("w8_shl_sr", {7'h0, bus8.s_right_dout}, 8'h00);
        drive8(SEL_HOLD, 8'hFF, 1'b1, 1'b1);
        step(); check("w8_hold", bus8.p_dout, 8'b1011_0010);
        #2 rst_n = 1'b0;
        #1 check("w8_async_rst", bus8.p_dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
